disp_scan_bcd: RTL
==================

# disp_scan_bcd

Downstream display stage for the counter/sequence core: accepts a binary result word with a one-cycle load strobe, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the board's 8-digit common-anode seven-segment display. Digits 0-4 show the decimal value, digit 7 shows a 4-bit hex tag (program/mode), and digits 5-6 stay blank. The converted value is committed atomically, so the display never shows a half-converted number.

## Interface
- WIDTH, 16: binary input width; BCD result is fixed at 5 digits, so WIDTH ≤ 16.
- SCAN_DIV, 4: clock cycles each digit is driven (100000 on board, 4 in simulation).
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  WIDTH  binary word to display; sampled only on an accepted load.
- load  in  1  one-cycle strobe requesting conversion of value.
- tag  in  4  hex glyph for digit 7; sampled with value.
- dp_in  in  1  decimal point on digit 0 (parity flag); sampled with value.
- blank  in  1  level; forces all anodes off while high.
- busy  out  1  conversion in progress.
- an  out  8  anode enables, active-low, an[i] = digit i.
- dec_cat  out  8  cathodes, active-low, {a,b,c,d,e,f,g,dp}.

## Operation
- Reset: busy=0, an=8'hFF, dec_cat=8'hFF, committed digits = 0, tag = 0, dp = 0, scan index = 0, divider = 0.
- States: IDLE, SHIFT, COMMIT.
- IDLE: load=1 captures value, tag and dp_in into shadow registers, clears the BCD accumulator, and enters SHIFT.
- SHIFT: runs WIDTH iterations, one per cycle. Each iteration adds 3 to any BCD nibble ≥ 5, then shifts the {BCD, binary} pair left by 1. After iteration WIDTH the block enters COMMIT.
- COMMIT: copies the 5 BCD digits, tag and dp to the display registers in a single cycle, then returns to IDLE.
- A load while busy=1 is ignored, with no queuing. A load in the same cycle as reset is lost.
- Scan: the divider counts 0..SCAN_DIV-1. On the terminal count the index advances, wrapping 7 to 0.
  - an has a single 0 bit at the current index.
  - dec_cat shows the glyph for the current index: digits 0-4 are BCD 0-9; digits 5-6 are blank (8'hFF); digit 7 is the hex tag.
- Glyph encodings:
  - 0 = 8'h03, 1 = 8'h9F, 2 = 8'h25, 3 = 8'h0D, 4 = 8'h99, 5 = 8'h49, 6 = 8'h41, 7 = 8'h1F, 8 = 8'h01, 9 = 8'h09.
  - A-F use standard glyphs, with dp off.
  - dp on clears bit 0, and applies to digit 0 only.
- blank=1 drives an=8'hFF. Scanning and conversion continue underneath.
- Reset mid-conversion aborts the conversion and restores all reset values, including clearing the display digits.

## Timing
- an and dec_cat are registered and change together in the same cycle. There is no segment-ghosting cycle.
- First cycle after reset deasserts: an=8'hFE, dec_cat=8'h03.
- busy rises the cycle after the accepted load and stays high for WIDTH+1 cycles (SHIFT plus COMMIT).
- New digits are visible from the cycle after busy falls, on whichever digit is then scanned.
- Load-to-commit latency is WIDTH+1 cycles.
- A load is accepted again in the first cycle busy=0.
- Full scan period = 8·SCAN_DIV cycles. The scan phase is unaffected by load.

## Configuration
- LEADING_ZERO_BLANK_EN defined: zero digits above the most significant non-zero digit among 0-4 are blanked (8'hFF). Digit 0 is always shown, so value 0 shows a single "0".
- LEADING_ZERO_BLANK_EN undefined: all five decimal digits are always shown, with zero-padding.

## Test plan
- Reset held 3 cycles, then released -> an=8'hFF and dec_cat=8'hFF during reset; first cycle after release gives an=8'hFE, dec_cat=8'h03; an advances every 4 cycles, 8'hFD next.
- load with value=12345, tag=4'h3, dp_in=1 -> busy high for exactly 17 cycles. After that, the digits read:
  - digit0 = 8'h48 (5 with dp)
  - digit1 = 8'h99
  - digit2 = 8'h0D
  - digit3 = 8'h25
  - digit4 = 8'h9F
  - digit5 and digit6 = 8'hFF
  - digit7 = 8'h0D
- Boundary value=65535 -> digits 0-4 = 5, 3, 5, 5, 6; value=0 without the macro shows "00000".
- load=1 with value=99 while busy -> ignored; display keeps the prior value, and busy length is unchanged.
- LEADING_ZERO_BLANK_EN with value=7 -> digit0=8'h1F, digits 1-4 = 8'hFF; value=0 -> digit0=8'h03, digits 1-4 = 8'hFF.
- Reset asserted at the 8th cycle of busy -> next cycle busy=0 and an=8'hFF; after release, digit 0 shows 8'h03. blank=1 for 10 cycles -> an=8'hFF, and the scan index resumes in phase afterwards.

Source files
------------

// File: rtl/disp_scan_bcd.sv
// Binary-to-BCD (sequential double-dabble) converter feeding an 8-digit multiplexed common-anode display.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero digit (1-4).
module disp_scan_bcd #(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic [3:0]       tag,
    input  logic             dp_in,
    input  logic             blank,
    output logic             busy,
    output logic [7:0]       an,
    output logic [7:0]       dec_cat
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [19:0]        bcd_q, bcd_d;
    logic [3:0]         tag_sh_q, tag_sh_d;
    logic               dp_sh_q, dp_sh_d;
    logic               commit;

    logic [19:0]        disp_q;
    logic [3:0]         disp_tag_q;
    logic               disp_dp_q;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         an_q, an_d;
    logic [7:0]         cat_q, cat_d;
    logic [4:1]         lz;

    // One double-dabble iteration: +3 on every nibble >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic msb);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj[18:0], msb};
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;
            4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;
            4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
            4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;
            4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
            4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;
            4'hE: glyph = 8'h61;  default: glyph = 8'h71;
        endcase
    endfunction

    // Conversion FSM: state register, next-state, outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            disp_q     <= '0;
            disp_tag_q <= '0;
            disp_dp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                disp_q     <= bcd_q;
                disp_tag_q <= tag_sh_q;
                disp_dp_q  <= dp_sh_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        bin_q    <= bin_d;
        bcd_q    <= bcd_d;
        tag_sh_q <= tag_sh_d;
        dp_sh_q  <= dp_sh_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        tag_sh_d = tag_sh_q;
        dp_sh_d  = dp_sh_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    bin_d    = value;
                    bcd_d    = '0;
                    tag_sh_d = tag;
                    dp_sh_d  = dp_in;
                end
            end
            SHIFT: begin
                bcd_d = dabble_step(bcd_q, bin_q[WIDTH-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        commit = (state_q == COMMIT);
    end

    // Scan: free-running divider and digit index, independent of conversion.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lz[4] = (disp_q[19:16] == 4'd0);
        lz[3] = lz[4] && (disp_q[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
`else
        lz = '0;
`endif
    end

    always_comb begin
        an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
        cat_d = 8'hFF;
        case (idx_q)
            3'd0: cat_d = glyph(disp_q[3:0]) & {7'h7F, ~disp_dp_q};
            3'd1: cat_d = lz[1] ? 8'hFF : glyph(disp_q[7:4]);
            3'd2: cat_d = lz[2] ? 8'hFF : glyph(disp_q[11:8]);
            3'd3: cat_d = lz[3] ? 8'hFF : glyph(disp_q[15:12]);
            3'd4: cat_d = lz[4] ? 8'hFF : glyph(disp_q[19:16]);
            3'd7: cat_d = glyph(disp_tag_q);
            default: cat_d = 8'hFF;
        endcase
    end

    // Anodes and cathodes register together so a digit switch never ghosts.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            cat_q <= 8'hFF;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            cat_q <= cat_d;
        end
    end

    assign an      = an_q;
    assign dec_cat = cat_q;

endmodule
